cdr_phase_picker: RTL



---
 rtl/cdr_pkg.sv | 47 ++++
 rtl/cdr_phase_picker_edge_vote.sv | 37 +++
 rtl/cdr_phase_picker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cdr_pkg.sv
// -----------------------------------------------------------------------------
// cdr_pkg
// Shared definitions for the oversampling CDR phase picker:
//   NB_ZERO/NB_ONE/NB_TWO  encodings of the nbits_o output
//   MAX_OSR                widest oversampled word the helpers accept
//   wrap_dist()            signed edge distance wrapped to [-osr/2, osr/2-1]
//   vote_sum()             signed early/late vote over an edge vector
// Configuration macro used by the block: CDR_MAJORITY_VOTE_EN (see top).
// -----------------------------------------------------------------------------
package cdr_pkg;

    localparam logic [1:0] NB_ZERO = 2'd0;
    localparam logic [1:0] NB_ONE  = 2'd1;
    localparam logic [1:0] NB_TWO  = 2'd2;

    localparam int MAX_OSR = 64;

    // Distance of an edge at t from the ideal position ti, both in [0, osr).
    function automatic int wrap_dist(input int t, input int ti, input int osr);
        int d;
        d = (t - ti + osr) % osr;
        if (d >= osr / 2) begin
            d = d - osr;
        end
        return d;
    endfunction

    // +1 per late edge, -1 per early edge, nothing for an edge exactly at ti.
    function automatic int vote_sum(input logic [MAX_OSR-1:0] edges,
                                    input int ti, input int osr);
        int v;
        int d;
        v = 0;
        for (int t = 0; t < MAX_OSR; t++) begin
            if (t < osr && edges[t]) begin
                d = wrap_dist(t, ti, osr);
                if (d > 0) begin
                    v = v + 1;
                end else if (d < 0) begin
                    v = v - 1;
                end
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/cdr_phase_picker_edge_vote.sv
// -----------------------------------------------------------------------------
// cdr_edge_vote
// Combinational edge detector and early/late voter for one oversampled word.
// Ports:
//   samples_i [OSR]           word, MSB is the oldest sample (t=0)
//   prev_i                    last sample of the previous word (t=-1)
//   ph_i      [$clog2(OSR)]   current pick phase
//   vote_o    signed          net late(+)/early(-) vote for the word
// -----------------------------------------------------------------------------
module cdr_edge_vote
    import cdr_pkg::*;
#(
    parameter int OSR = 8
) (
    input  logic [OSR-1:0]                samples_i,
    input  logic                          prev_i,
    input  logic [$clog2(OSR)-1:0]        ph_i,
    output logic signed [$clog2(OSR)+1:0] vote_o
);

    localparam int VW = $clog2(OSR) + 2;

    logic [MAX_OSR-1:0] edges;
    int                 ti;

    always_comb begin
        edges = '0;
        // s[t] lives at samples_i[OSR-1-t]
        edges[0] = prev_i ^ samples_i[OSR-1];
        for (int t = 1; t < OSR; t++) begin
            edges[t] = samples_i[OSR-t] ^ samples_i[OSR-1-t];
        end
        ti     = (int'(ph_i) + OSR / 2) % OSR;
        vote_o = VW'(vote_sum(edges, ti, OSR));
    end

endmodule

// File: rtl/cdr_phase_picker.sv
// -----------------------------------------------------------------------------
// cdr_phase_picker
// Tracks the data-edge position inside an OSR-times oversampled stream with a
// saturating early/late accumulator and picks the bit-centre sample, emitting
// 0, 1 or 2 bits per word so phase wraps absorb frequency offset.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   valid_i, samples_i    input word strobe and OSR-sample word (MSB oldest)
//   valid_o               outputs valid (one cycle after the consumed word)
//   bits_o[1:0]           recovered bits, bits_o[1] earlier
//   nbits_o[1:0]          number of valid bits (NB_ZERO/NB_ONE/NB_TWO)
//   phase_o               current pick phase
//   locked_o              LOCK_CNT valid words seen without a phase step
// Macro CDR_MAJORITY_VOTE_EN: each bit becomes the majority of three adjacent
// samples; the word is delayed one valid word so s[OSR] is available.
// -----------------------------------------------------------------------------
module cdr_phase_picker
    import cdr_pkg::*;
#(
    parameter int OSR      = 8,
    parameter int THRESH   = 4,
    parameter int LOCK_CNT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic [OSR-1:0]         samples_i,
    output logic                   valid_o,
    output logic [1:0]             bits_o,
    output logic [1:0]             nbits_o,
    output logic [$clog2(OSR)-1:0] phase_o,
    output logic                   locked_o
);

    localparam int PW      = $clog2(OSR);
    localparam int VW      = PW + 2;
    localparam int ACC_MAX = THRESH + OSR;
    localparam int AW      = $clog2(ACC_MAX + 1) + 2;
    localparam int LW      = $clog2(LOCK_CNT + 1);

    localparam logic signed [AW-1:0] ACC_HI = AW'(ACC_MAX);
    localparam logic signed [AW-1:0] ACC_LO = -ACC_HI;
    localparam logic signed [AW-1:0] TH_HI  = AW'(THRESH);
    localparam logic signed [AW-1:0] TH_LO  = -TH_HI;

`ifdef CDR_MAJORITY_VOTE_EN
    localparam int SRC_W = OSR + 2;
`else
    localparam int SRC_W = OSR;
`endif

    logic signed [AW-1:0] acc_q, acc_d, acc_sum;
    logic [PW-1:0]        ph_q, ph_d;
    logic                 prev_q, prev_d;
    logic [LW-1:0]        lock_q, lock_d;
    logic                 wrap_p_q, wrap_p_d;
    logic                 wrap_n_q, wrap_n_d;
    logic                 valid_q, valid_d;
    logic [1:0]           bits_q, bits_d;
    logic [1:0]           nbits_q, nbits_d;

    logic                 word_vld;
    logic [OSR-1:0]       word;
    logic [SRC_W-1:0]     src;
    logic signed [VW-1:0] vote;

    function automatic logic signed [AW-1:0] sat_acc(input logic signed [AW-1:0] x);
        if (x > ACC_HI) begin
            return ACC_HI;
        end else if (x < ACC_LO) begin
            return ACC_LO;
        end
        return x;
    endfunction

    // Sample (or three-sample majority) at pick index p of the current word.
    function automatic logic pick_bit(input logic [SRC_W-1:0] v, input int p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < OSR; i++) begin
            if (i == p) begin
`ifdef CDR_MAJORITY_VOTE_EN
                // v = {s[-1], s[0..OSR-1], s[OSR]}; s[tau] at bit OSR-tau
                r = (v[OSR+1-i] & v[OSR-i]) | (v[OSR+1-i] & v[OSR-1-i]) |
                    (v[OSR-i] & v[OSR-1-i]);
`else
                r = v[OSR-1-i];
`endif
            end
        end
        return r;
    endfunction

`ifdef CDR_MAJORITY_VOTE_EN
    logic [OSR-1:0] dly_q;
    logic           dly_vld_q, dly_vld_d;

    // The delayed word is processed once its successor supplies s[OSR].
    assign word     = dly_q;
    assign word_vld = valid_i & dly_vld_q;
    assign src      = {prev_q, dly_q, samples_i[OSR-1]};
    assign dly_vld_d = dly_vld_q | valid_i;

    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            dly_q <= samples_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dly_vld_q <= 1'b0;
        end else begin
            dly_vld_q <= dly_vld_d;
        end
    end
`else
    assign word     = samples_i;
    assign word_vld = valid_i;
    assign src      = samples_i;
`endif

    cdr_edge_vote #(.OSR(OSR)) u_edge_vote (
        .samples_i (word),
        .prev_i    (prev_q),
        .ph_i      (ph_q),
        .vote_o    (vote)
    );

    always_comb begin
        acc_d    = acc_q;
        ph_d     = ph_q;
        prev_d   = prev_q;
        lock_d   = lock_q;
        wrap_p_d = wrap_p_q;
        wrap_n_d = wrap_n_q;
        valid_d  = 1'b0;
        bits_d   = bits_q;
        nbits_d  = nbits_q;
        acc_sum  = sat_acc(acc_q + AW'(vote));

        if (word_vld) begin
            valid_d  = 1'b1;
            // A pending wrap from the previous word decides how many bits go out.
            if (wrap_p_q) begin
                nbits_d = NB_ZERO;
                bits_d  = 2'b00;
            end else if (wrap_n_q) begin
                nbits_d = NB_TWO;
                bits_d  = {pick_bit(src, 0), pick_bit(src, OSR - 1)};
            end else begin
                nbits_d = NB_ONE;
                bits_d  = {1'b0, pick_bit(src, int'(ph_q))};
            end
            wrap_p_d = 1'b0;
            wrap_n_d = 1'b0;
            prev_d   = word[0];

            if (acc_sum >= TH_HI) begin
                ph_d     = ph_q + PW'(1);
                acc_d    = '0;
                lock_d   = '0;
                wrap_p_d = (ph_q == PW'(OSR - 1));
            end else if (acc_sum <= TH_LO) begin
                ph_d     = ph_q - PW'(1);
                acc_d    = '0;
                lock_d   = '0;
                wrap_n_d = (ph_q == '0);
            end else begin
                acc_d = acc_sum;
                if (lock_q != LW'(LOCK_CNT)) begin
                    lock_d = lock_q + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            ph_q     <= '0;
            prev_q   <= 1'b0;
            lock_q   <= '0;
            wrap_p_q <= 1'b0;
            wrap_n_q <= 1'b0;
            valid_q  <= 1'b0;
            bits_q   <= '0;
            nbits_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            ph_q     <= ph_d;
            prev_q   <= prev_d;
            lock_q   <= lock_d;
            wrap_p_q <= wrap_p_d;
            wrap_n_q <= wrap_n_d;
            valid_q  <= valid_d;
            bits_q   <= bits_d;
            nbits_q  <= nbits_d;
        end
    end

    assign valid_o  = valid_q;
    assign bits_o   = bits_q;
    assign nbits_o  = nbits_q;
    assign phase_o  = ph_q;
    assign locked_o = (lock_q == LW'(LOCK_CNT));

endmodule
